prog_mem_loader: RTL and testbench
==================================

PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

Interface
REQ-001 Reset is `reset`: synchronous, active-high.
REQ-002 Port: ph1  in  1  two-phase non-overlapping clock, phase 1.
REQ-003 Port: ph2  in  1  two-phase clock, phase 2; all state updates on ph2.
REQ-004 Port: reset  in  1  synchronous active-high reset, sampled on ph2.
REQ-005 Port: Adr  in  8  processor address.
REQ-006 Port: MemWrite  in  1  processor store strobe.
REQ-007 Port: MemData1  out  7  word bits [14:8] at Adr.
REQ-008 Port: MemData2  inout  8  word bits [7:0]; read data out, store data in.
REQ-009 Port: load_en  in  1  level; while high, the loader owns the memory.
REQ-010 Port: sdata  in  1  serial program bit, word MSB (bit 14) first.
REQ-011 Port: svalid  in  1  sdata qualifier, one bit accepted per cycle.
REQ-012 Port: cpu_reset  out  1  reset to the processor.
REQ-013 Port: load_count  out  8  words written since load start, mod 256.
REQ-014 Port: load_ovf  out  1  sticky flag: more than 256 words loaded.

Function
REQ-015 Storage shall be 256 x 15-bit words; contents are not cleared by reset.
REQ-016 Reads shall be combinational from Adr, so data is valid in the same cycle for the processor's ph2 capture.
REQ-017 MemData2 shall be driven only when MemWrite=0 and state=RUN; otherwise it is high-Z.
REQ-018 When MemWrite=1 in RUN, the word at Adr shall take bits [7:0]=MemData2 during ph2; bits [14:8] are preserved.
REQ-019 FSM states: RUN, LOAD, RELEASE.
REQ-020 Transition RUN->LOAD on load_en=1. On entry: bit_cnt=0, ld_adr=0, load_count=0, load_ovf=0.
REQ-021 In LOAD, each cycle with svalid=1 shall shift sdata into a 14-bit shift register and increment bit_cnt (0..14).
REQ-022 When the 15th bit is accepted (bit_cnt=14 and svalid=1), the following shall happen in that same ph2:
  - write word {sr[13:0], sdata} to ld_adr;
  - ld_adr += 1;
  - load_count += 1;
  - bit_cnt = 0.
REQ-023 ld_adr and load_count shall wrap 255->0; a write at ld_adr=255 shall set load_ovf on the next word written.
REQ-024 In LOAD, processor MemWrite shall be ignored.
REQ-025 Transition LOAD->RELEASE on load_en=0. A partial word (bit_cnt!=0) shall be discarded, and svalid is ignored in that cycle.
REQ-026 Transition RELEASE->RUN unconditionally after 1 cycle; if load_en=1 in RELEASE, go to LOAD instead.
REQ-027 cpu_reset shall equal reset OR (state != RUN); it is a registered state decode plus reset, glitch-free across ph1.
REQ-028 Latency: the last bit is accepted in cycle N, load_en falls at cycle N+1, and cpu_reset falls at cycle N+3 (one LOAD->RELEASE cycle, one RELEASE cycle).
REQ-029 Simultaneous load_en rising and MemWrite in RUN: the store shall complete in that cycle, then the FSM enters LOAD.

Reset
REQ-030 On reset=1, the following shall be set at the next ph2:
  - state=RUN;
  - bit_cnt=0, ld_adr=0, load_count=0, load_ovf=0;
  - shift register=0.
REQ-031 cpu_reset shall be 1 while reset=1.
REQ-032 Reset mid-load shall abort the load; words already written are retained and the partial word is discarded.
REQ-033 No memory write shall occur in a cycle with reset=1.

Structure
REQ-034 Shared package mem_pkg shall hold the following:
  - WORD_W=15, ADR_W=8, DEPTH=256;
  - the FSM state enum ldr_state_t {RUN, LOAD, RELEASE}.
REQ-035 One sub-module, load_shifter, shall contain the shift register and bit counter and produce word_done and word[14:0].
REQ-036 Latches shall use the existing ph1/ph2 master-slave flop style; the memory array shall use a ph2 write latch.

Verification
REQ-037 Load 3 words 0x7FFF, 0x1234, 0x0001 (45 bits, svalid=1), then drop load_en -> mem[0..2] hold those values, load_count=3, cpu_reset=0 two cycles after load_en falls.
REQ-038 Load 1 word with svalid toggling every other cycle -> word still equals its 15 shifted bits; load_count increments only after the 15th valid bit.
REQ-039 RUN: Adr=0x10, MemWrite=1, MemData2=0xA5, with mem[0x10]=0x7F00 -> mem[0x10]=0x7FA5; next read with MemWrite=0 drives MemData2=0xA5, MemData1=0x7F.
REQ-040 Load 257 words -> mem[0] holds word 256, load_count=1, load_ovf=1.
REQ-041 Assert reset after 2 words plus 7 bits -> state=RUN, cpu_reset=1 during reset, mem[0..1] retained, mem[2] unchanged.
REQ-042 load_en drops with bit_cnt=9 -> no write, load_count unchanged, RELEASE for one cycle, then RUN.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and sizes for the program memory loader.
// Holds memory geometry, FSM states and the inter-stage bundles.
package mem_pkg;

  localparam int WORD_W = 15;
  localparam int ADR_W  = 8;
  localparam int DEPTH  = 256;
  localparam int CNT_W  = 4;

  localparam logic [CNT_W-1:0] LAST_BIT = 4'd14;

  typedef enum logic [1:0] {
    RUN,
    LOAD,
    RELEASE
  } ldr_state_t;

  typedef struct packed {
    ldr_state_t       state;
    logic [ADR_W-1:0] ld_adr;
    logic [ADR_W-1:0] count;
    logic             ovf;
    logic             wrap;
    logic             busy;
  } ldr_regs_t;

  typedef struct packed {
    logic              we;
    logic              byte_only;
    logic [ADR_W-1:0]  adr;
    logic [WORD_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/prog_mem_loader_if.sv
// Serial program-load port of the loader.
// Master side streams bits; slave side reports progress.
interface prog_mem_loader_if;
  import mem_pkg::*;

  logic             load_en;
  logic             sdata;
  logic             svalid;
  logic             cpu_reset;
  logic [ADR_W-1:0] load_count;
  logic             load_ovf;

  modport master (
    output load_en, sdata, svalid,
    input  cpu_reset, load_count, load_ovf
  );

  modport slave (
    input  load_en, sdata, svalid,
    output cpu_reset, load_count, load_ovf
  );

endinterface

// File: rtl/load_shifter.sv
// Serial-to-parallel word assembler, MSB first.
// Flags word_done in the cycle the 15th bit is accepted.
module load_shifter
  import mem_pkg::*;
(
  input  logic              ph1,
  input  logic              ph2,
  input  logic              clr,
  input  logic              shift,
  input  logic              sdata,
  output logic              word_done,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-2:0] sr_q, sr_m, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_m, cnt_d;

  assign word = {sr_q, sdata};

  // next shift/count; clr and shift are never both high
  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    unique case (1'b1)
      clr: begin
        sr_d  = '0;
        cnt_d = '0;
      end
      shift && (cnt_q == LAST_BIT): begin
        word_done = 1'b1;
        sr_d      = '0;
        cnt_d     = '0;
      end
      shift && (cnt_q != LAST_BIT): begin
        sr_d  = {sr_q[WORD_W-3:0], sdata};
        cnt_d = cnt_q + 4'd1;
      end
      default: ;
    endcase
  end

  // master half: capture at ph1 fall
  always_ff @(negedge ph1) begin
    sr_m  <= sr_d;
    cnt_m <= cnt_d;
  end

  // slave half: publish on ph2
  always_ff @(posedge ph2) begin
    sr_q  <= sr_m;
    cnt_q <= cnt_m;
  end

endmodule

// File: rtl/prog_mem_loader.sv
// 256x15 program memory with a serial loader that holds the CPU
// in reset while a program image is streamed in.
module prog_mem_loader
  import mem_pkg::*;
(
  input  logic             ph1,
  input  logic             ph2,
  input  logic             reset,
  input  logic [ADR_W-1:0] Adr,
  input  logic             MemWrite,
  output logic [6:0]       MemData1,
  inout  wire  [7:0]       MemData2,
  prog_mem_loader_if.slave ld
);

  ldr_regs_t         regs_q, regs_m, regs_d;
  wr_req_t           wr_d, wr_m;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rd;
  logic [WORD_W-1:0] word;
  logic              shift, clr;
  logic              word_done;
  logic              entering;
  logic              drive;

  assign shift = (regs_q.state == LOAD) && ld.load_en
              && ld.svalid && !reset;
  assign clr   = reset || (regs_q.state != LOAD)
              || !ld.load_en;

  load_shifter u_shift (
    .ph1       (ph1),
    .ph2       (ph2),
    .clr       (clr),
    .shift     (shift),
    .sdata     (ld.sdata),
    .word_done (word_done),
    .word      (word)
  );

  // master half of state flop: capture at ph1 fall
  always_ff @(negedge ph1) begin
    regs_m <= regs_d;
    wr_m   <= wr_d;
  end

  // slave half: state updates on ph2
  always_ff @(posedge ph2) begin
    regs_q <= regs_m;
  end

  // next state and load bookkeeping
  always_comb begin
    regs_d = regs_q;
    if (reset) begin
      regs_d.state = RUN;
    end else begin
      unique case (regs_q.state)
        RUN:     if (ld.load_en) regs_d.state = LOAD;
        LOAD:    if (!ld.load_en) regs_d.state = RELEASE;
        RELEASE: regs_d.state = ld.load_en ? LOAD : RUN;
        default: regs_d.state = RUN;
      endcase
    end
    entering = (regs_q.state != LOAD)
            && (regs_d.state == LOAD);
    unique case (1'b1)
      reset || entering: begin
        regs_d.ld_adr = '0;
        regs_d.count  = '0;
        regs_d.ovf    = 1'b0;
        regs_d.wrap   = 1'b0;
      end
      word_done: begin
        regs_d.ld_adr = regs_q.ld_adr + 8'd1;
        regs_d.count  = regs_q.count + 8'd1;
        regs_d.wrap   = regs_q.wrap
                     || (regs_q.ld_adr == 8'hFF);
        regs_d.ovf    = regs_q.ovf || regs_q.wrap;
      end
      default: ;
    endcase
    // registered decode keeps cpu_reset glitch-free
    regs_d.busy = (regs_d.state != RUN);
  end

  // bus drive and write request; loader wins in LOAD
  always_comb begin
    wr_d  = '0;
    drive = (regs_q.state == RUN) && !MemWrite;
    if (word_done) begin
      wr_d.we   = 1'b1;
      wr_d.adr  = regs_q.ld_adr;
      wr_d.data = word;
    end else if (!reset && (regs_q.state == RUN)
                 && MemWrite) begin
      wr_d.we        = 1'b1;
      wr_d.byte_only = 1'b1;
      wr_d.adr       = Adr;
      wr_d.data      = {{(WORD_W-8){1'b0}}, MemData2};
    end
  end

  // array write on ph2 from ph1-captured request
  always_ff @(posedge ph2) begin
    if (wr_m.we) begin
      if (wr_m.byte_only)
        mem[wr_m.adr][7:0] <= wr_m.data[7:0];
      else
        mem[wr_m.adr] <= wr_m.data;
    end
  end

  assign rd           = mem[Adr];
  assign MemData1     = rd[14:8];
  assign MemData2     = drive ? rd[7:0] : 8'bz;
  assign ld.cpu_reset  = reset || regs_q.busy;
  assign ld.load_count = regs_q.count;
  assign ld.load_ovf   = regs_q.ovf;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader.
// Read-back vectors in a table, corner cases hand-sequenced.
module tb_prog_mem_loader;

  logic       ph1, ph2;
  logic       reset;
  logic       mem_write;
  logic [7:0] adr;
  wire  [6:0] md1;
  wire  [7:0] md2;
  logic       drv_en;
  logic [7:0] drv_val;

  int errors = 0;
  int checks = 0;

  assign md2 = drv_en ? drv_val : 8'bz;

  prog_mem_loader_if bus ();

  prog_mem_loader dut (
    .ph1      (ph1),
    .ph2      (ph2),
    .reset    (reset),
    .Adr      (adr),
    .MemWrite (mem_write),
    .MemData1 (md1),
    .MemData2 (md2),
    .ld       (bus)
  );

  typedef struct {
    int          phase;
    logic [7:0]  a;
    logic [14:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [16];

  initial begin
    ph1 = 1'b0;
    ph2 = 1'b0;
    forever begin
      #1 ph1 = 1'b1;
      #3 ph1 = 1'b0;
      #2 ph2 = 1'b1;
      #3 ph2 = 1'b0;
      #1;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ph2);
    #1;
  endtask

  task automatic send_bits(input logic [14:0] w,
                           input int n);
    for (int i = 14; i > 14 - n; i--) begin
      bus.sdata  = w[i];
      bus.svalid = 1'b1;
      tick();
    end
    bus.svalid = 1'b0;
  endtask

  task automatic start_load();
    bus.load_en = 1'b1;
    bus.svalid  = 1'b0;
    tick();
    chk("load_cpu_reset", bus.cpu_reset, 1);
  endtask

  task automatic end_load();
    bus.load_en = 1'b0;
    bus.svalid  = 1'b0;
    tick();
    chk("release_cpu_reset", bus.cpu_reset, 1);
    tick();
    chk("run_cpu_reset", bus.cpu_reset, 0);
  endtask

  task automatic check_reads(input int ph);
    mem_write = 1'b0;
    drv_en    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].phase == ph) begin
        adr = vecs[i].a;
        #1;
        chk($sformatf("rd%0d_%02h", ph, vecs[i].a),
            {17'd0, md1, md2}, {17'd0, vecs[i].exp});
      end
    end
  endtask

  initial begin
    logic [14:0] w;
    int k;

    vecs[0]  = '{1, 8'h00, 15'h7FFF};
    vecs[1]  = '{1, 8'h01, 15'h1234};
    vecs[2]  = '{1, 8'h02, 15'h0001};
    vecs[3]  = '{2, 8'h00, 15'h0F0F};
    vecs[4]  = '{2, 8'h01, 15'h70F0};
    vecs[5]  = '{2, 8'h02, 15'h0001};
    vecs[6]  = '{3, 8'h00, 15'h2A5C};
    vecs[7]  = '{3, 8'h01, 15'h70F0};
    vecs[8]  = '{3, 8'h02, 15'h0001};
    vecs[9]  = '{4, 8'h00, 15'h0ABC};
    vecs[10] = '{4, 8'h01, 15'h70F0};
    vecs[11] = '{5, 8'h10, 15'h7F3C};
    vecs[12] = '{5, 8'h01, 15'h0101};
    vecs[13] = '{6, 8'h00, 15'h4321};
    vecs[14] = '{6, 8'h01, 15'h0004};
    vecs[15] = '{6, 8'hFF, 15'h02FE};

    reset       = 1'b1;
    bus.load_en = 1'b0;
    bus.sdata   = 1'b0;
    bus.svalid  = 1'b0;
    mem_write   = 1'b0;
    adr         = 8'h00;
    drv_en      = 1'b0;
    drv_val     = 8'h00;

    tick();
    tick();
    chk("rst_cpu_reset", bus.cpu_reset, 1);
    chk("rst_count", bus.load_count, 0);
    chk("rst_ovf", bus.load_ovf, 0);
    reset = 1'b0;
    tick();
    chk("run_after_rst", bus.cpu_reset, 0);

    // three back-to-back words
    start_load();
    send_bits(15'h7FFF, 15);
    send_bits(15'h1234, 15);
    send_bits(15'h0001, 15);
    chk("three_count", bus.load_count, 3);
    chk("three_ovf", bus.load_ovf, 0);
    end_load();
    check_reads(1);

    // reset after 2 words + 7 bits
    start_load();
    send_bits(15'h0F0F, 15);
    send_bits(15'h70F0, 15);
    send_bits(15'h7FFF, 7);
    bus.svalid = 1'b1;
    bus.sdata  = 1'b1;
    reset      = 1'b1;
    tick();
    chk("midrst_cpu_reset", bus.cpu_reset, 1);
    chk("midrst_count", bus.load_count, 0);
    reset       = 1'b0;
    bus.load_en = 1'b0;
    bus.svalid  = 1'b0;
    tick();
    chk("midrst_run", bus.cpu_reset, 0);
    check_reads(2);

    // gapped svalid; CPU store attempt ignored
    start_load();
    mem_write = 1'b1;
    adr       = 8'h02;
    drv_en    = 1'b1;
    drv_val   = 8'hEE;
    w = 15'h2A5C;
    k = 14;
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) begin
        bus.svalid = 1'b1;
        bus.sdata  = w[k];
        k--;
      end else begin
        bus.svalid = 1'b0;
        bus.sdata  = ~bus.sdata;
      end
      if (i == 28)
        chk("gap_count_pre", bus.load_count, 0);
      tick();
    end
    chk("gap_count_post", bus.load_count, 1);
    mem_write = 1'b0;
    drv_en    = 1'b0;
    end_load();
    check_reads(3);

    // drop load_en mid-word (bit_cnt = 9)
    start_load();
    send_bits(15'h0ABC, 15);
    send_bits(15'h7FFF, 9);
    bus.load_en = 1'b0;
    bus.svalid  = 1'b1;
    bus.sdata   = 1'b1;
    tick();
    chk("partial_release", bus.cpu_reset, 1);
    chk("partial_count", bus.load_count, 1);
    bus.svalid = 1'b0;
    tick();
    chk("partial_run", bus.cpu_reset, 0);
    chk("partial_count2", bus.load_count, 1);
    check_reads(4);

    // 17 words so mem[0x10] = 0x7F00, then byte store
    start_load();
    for (int i = 0; i < 17; i++) begin
      w = (i == 16) ? 15'h7F00 : 15'(i * 32'h101);
      send_bits(w, 15);
    end
    end_load();
    chk("seventeen_count", bus.load_count, 17);
    adr       = 8'h10;
    mem_write = 1'b1;
    drv_en    = 1'b1;
    drv_val   = 8'hA5;
    tick();
    mem_write = 1'b0;
    drv_en    = 1'b0;
    #1;
    chk("store_lo", md2, 8'hA5);
    chk("store_hi", md1, 7'h7F);

    // store and load_en rise together
    mem_write   = 1'b1;
    drv_en      = 1'b1;
    drv_val     = 8'h3C;
    bus.load_en = 1'b1;
    tick();
    chk("simul_cpu_reset", bus.cpu_reset, 1);
    chk("simul_count", bus.load_count, 0);
    mem_write = 1'b0;
    drv_en    = 1'b0;
    end_load();
    check_reads(5);

    // 257 words: wrap and overflow
    start_load();
    for (int i = 0; i < 257; i++) begin
      if (i == 256) begin
        chk("wrap_count_pre", bus.load_count, 0);
        chk("wrap_ovf_pre", bus.load_ovf, 0);
      end
      w = (i == 256) ? 15'h4321 : 15'(i * 3 + 1);
      send_bits(w, 15);
    end
    chk("wrap_count", bus.load_count, 1);
    chk("wrap_ovf", bus.load_ovf, 1);
    end_load();
    chk("wrap_ovf_run", bus.load_ovf, 1);
    check_reads(6);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
